// File: rtl/demux_param_pkg.sv
// Shared types for the parameterised demultiplexer: payload types and lane state.
package MuxParam_pkg;

    // Operation codes; every 3-bit pattern is a legal member.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_AND   = 3'd5,
        OP_OR    = 3'd6,
        OP_XOR   = 3'd7
    } op_codes_e_t;

    // Memory control word carried as a structured payload.
    typedef struct packed {
        logic [1:0] cmd;
        logic [3:0] bank;
        logic [9:0] addr;
    } mem_ctl_st_t;

    // Occupancy of one 2-entry lane FIFO.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } lane_state_e_t;

    // A lane presents a head whenever it holds at least one entry.
    function automatic logic lane_has_data(input lane_state_e_t st);
        logic has_s;
        case (st)
            ONE:     has_s = 1'b1;
            FULL:    has_s = 1'b1;
            EMPTY:   has_s = 1'b0;
            default: has_s = 1'b0;
        endcase
        return has_s;
    endfunction

endpackage

// File: rtl/demux_param_lane.sv
// One output lane: 2-entry FIFO, occupancy state machine and pop counter.
// Outputs are decoded only from registers, so nothing upstream reaches them
// combinationally.
module demux_lane
    import MuxParam_pkg::*;
#(
    parameter type T     = op_codes_e_t,
    parameter int  CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 din,
    input  logic             out_ready,
    output T                 out_data,
    output logic             out_valid,
    output logic             full,
    output logic [CNT_W-1:0] out_count
);

    lane_state_e_t    state_r;
    lane_state_e_t    state_s;
    T                 head_r;
    T                 head_s;
    T                 tail_r;
    T                 tail_s;
    logic [CNT_W-1:0] count_r;
    logic             pop_s;

    assign out_valid = lane_has_data(state_r);
    assign full      = (state_r == FULL);
    assign out_data  = head_r;
    assign out_count = count_r;
    assign pop_s     = out_valid & out_ready;

    // Next occupancy and storage; a simultaneous push and pop in ONE replaces the head.
    always_comb begin
        state_s = state_r;
        head_s  = head_r;
        tail_s  = tail_r;
        case (state_r)
            EMPTY: begin
                if (push) begin
                    state_s = ONE;
                    head_s  = din;
                end else begin
                    state_s = EMPTY;
                end
            end
            ONE: begin
                if (push && pop_s) begin
                    state_s = ONE;
                    head_s  = din;
                end else if (push) begin
                    state_s = FULL;
                    tail_s  = din;
                end else if (pop_s) begin
                    state_s = EMPTY;
                end else begin
                    state_s = ONE;
                end
            end
            FULL: begin
                // A push cannot arrive here: in_ready is low while the lane is full.
                if (pop_s) begin
                    state_s = ONE;
                    head_s  = tail_r;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
    end

    // State, storage and delivery counter; reset clears everything and discards in-flight pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            head_r  <= T'('0);
            tail_r  <= T'('0);
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            head_r  <= head_s;
            tail_r  <= tail_s;
            if (pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/demux_param.sv
// Parameterised 1-to-N demultiplexer: each accepted payload is steered into
// the 2-entry FIFO of lane in_sel; every lane drains independently.
module demux_param
    import MuxParam_pkg::*;
#(
    parameter type T     = op_codes_e_t,
    parameter int  SEL   = 2,
    parameter int  CNT_W = 16,
    localparam int N     = 2 ** SEL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  T                        in_data,
    input  logic [SEL-1:0]          in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output T [N-1:0]                out_data,
    output logic [N-1:0]            out_valid,
    input  logic [N-1:0]            out_ready,
    output logic [N-1:0][CNT_W-1:0] out_count
);

    logic [N-1:0] lane_full_s;
    logic [N-1:0] push_s;

    // Ready depends only on the addressed lane's registered occupancy, not on in_valid.
    assign in_ready = ~lane_full_s[in_sel];

    // Route an accepted transfer to exactly one lane.
    always_comb begin
        push_s = {N{1'b0}};
        if (in_valid && in_ready) begin
            push_s[in_sel] = 1'b1;
        end else begin
            push_s = {N{1'b0}};
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        demux_lane #(
            .T     (T),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .push      (push_s[g]),
            .din       (in_data),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .full      (lane_full_s[g]),
            .out_count (out_count[g])
        );
    end

endmodule
